// File: rtl/eep_pkg.sv
// ============================================================================
// Module      : eep_pkg
// Description : Shared loader state encoding and byte-width constant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eep_pkg;

    localparam int c_byte_width = 8;

    localparam logic [2:0] c_st_cnt_lo  = 3'd0;
    localparam logic [2:0] c_st_cnt_hi  = 3'd1;
    localparam logic [2:0] c_st_data_lo = 3'd2;
    localparam logic [2:0] c_st_data_hi = 3'd3;
    localparam logic [2:0] c_st_chk     = 3'd4;
    localparam logic [2:0] c_st_run     = 3'd5;
    localparam logic [2:0] c_st_err     = 3'd6;

    typedef enum logic [2:0] {
        ST_CNT_LO  = c_st_cnt_lo,
        ST_CNT_HI  = c_st_cnt_hi,
        ST_DATA_LO = c_st_data_lo,
        ST_DATA_HI = c_st_data_hi,
        ST_CHK     = c_st_chk,
        ST_RUN     = c_st_run,
        ST_ERR     = c_st_err
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/eep_word_asm.sv
// ============================================================================
// Module      : eep_word_asm
// Description : Joins a low and a high byte into a word; one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eep_word_asm
    import eep_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_lo_load,
    input  logic                        i_hi_load,
    input  logic [c_byte_width-1:0]     i_byte,
    output logic [2*c_byte_width-1:0]   o_word,
    output logic                        o_word_done
);

    logic [c_byte_width-1:0]    lo_q, lo_d;
    logic [2*c_byte_width-1:0]  word_q, word_d;
    logic                       done_q, done_d;

    always_comb begin
        lo_d   = lo_q;
        word_d = word_q;
        done_d = i_hi_load;
        if (i_lo_load) begin
            lo_d = i_byte;
        end
        if (i_hi_load) begin
            word_d = {i_byte, lo_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            word_q <= word_d;
            done_q <= done_d;
        end
    end

    assign o_word      = word_q;
    assign o_word_done = done_q;

endmodule

`default_nettype wire

// File: rtl/eep_loader.sv
// ============================================================================
// Module      : eep_loader
// Description : Byte-stream code loader for the eep core (count, words, run).
//               Optional trailing XOR checksum: define EEP_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eep_loader
    import eep_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [WORD_WIDTH-1:0]   wr_data,
    output logic                    cpu_run,
    output logic                    load_err
);

    localparam logic [ADDR_WIDTH-1:0] c_idx_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef EEP_LOADER_CHECKSUM_EN
    localparam loader_state_e c_after_data = ST_CHK;
`else
    localparam loader_state_e c_after_data = ST_RUN;
`endif

    loader_state_e                  state_q, state_d;
    logic [c_byte_width-1:0]        cnt_lo_q, cnt_lo_d;
    logic [2*c_byte_width-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0]          idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
    logic                           in_ready_q, in_ready_d;
    logic                           cpu_run_q, cpu_run_d;
    logic                           load_err_q, load_err_d;
`ifdef EEP_LOADER_CHECKSUM_EN
    logic [c_byte_width-1:0]        checksum_q, checksum_d;
`endif

    logic                           w_accept;
    logic                           w_lo_load;
    logic                           w_hi_load;
    logic                           w_last_word;
    logic [2*c_byte_width-1:0]      w_count_in;
    logic [2*c_byte_width-1:0]      w_word;
    logic                           w_word_done;

    assign w_accept    = in_valid && in_ready_q;
    assign w_count_in  = {in_data, cnt_lo_q};
    assign w_last_word = (32'(idx_q) + 32'd1) == 32'(count_q);

    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        count_d   = count_q;
        idx_d     = idx_q;
        wr_addr_d = wr_addr_q;
        w_lo_load = 1'b0;
        w_hi_load = 1'b0;
`ifdef EEP_LOADER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        if (w_accept) begin
            case (state_q)
                ST_CNT_LO: begin
                    cnt_lo_d = in_data;
                    state_d  = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    count_d = w_count_in;
                    idx_d   = '0;
                    if (32'(w_count_in) > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (w_count_in == '0) begin
                        state_d = c_after_data;
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    w_lo_load = 1'b1;
                    state_d   = ST_DATA_HI;
`ifdef EEP_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q ^ in_data;
`endif
                end
                ST_DATA_HI: begin
                    w_hi_load = 1'b1;
                    wr_addr_d = idx_q;
`ifdef EEP_LOADER_CHECKSUM_EN
                    checksum_d = checksum_q ^ in_data;
`endif
                    // Index stops at N-1 so it never walks past the loaded range.
                    if (w_last_word) begin
                        state_d = c_after_data;
                    end else begin
                        idx_d   = idx_q + c_idx_one;
                        state_d = ST_DATA_LO;
                    end
                end
`ifdef EEP_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    state_d = (in_data == checksum_q) ? ST_RUN : ST_ERR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        in_ready_d = (state_d != ST_RUN) && (state_d != ST_ERR);
        cpu_run_d  = (state_d == ST_RUN);
        load_err_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CNT_LO;
            cnt_lo_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wr_addr_q  <= '0;
            in_ready_q <= 1'b0;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_lo_q   <= cnt_lo_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wr_addr_q  <= wr_addr_d;
            in_ready_q <= in_ready_d;
            cpu_run_q  <= cpu_run_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef EEP_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

    eep_word_asm u_word_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lo_load   (w_lo_load),
        .i_hi_load   (w_hi_load),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    assign in_ready = in_ready_q;
    assign wr_en    = w_word_done;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = w_word;
    assign cpu_run  = cpu_run_q;
    assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_eep_loader.sv
// ============================================================================
// Module      : tb_eep_loader
// Description : Scoreboard bench for eep_loader; honours EEP_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eep_loader;

    localparam int ADDR_WIDTH = 16;
    localparam int WORD_WIDTH = 16;
    localparam int DEPTH      = 256;

    logic                   clk      = 1'b0;
    logic                   rst_n    = 1'b0;
    logic                   in_valid = 1'b0;
    logic [7:0]             in_data  = 8'h00;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [WORD_WIDTH-1:0]  wr_data;
    logic                   cpu_run;
    logic                   load_err;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    logic        prev_wr_en = 1'b0;

    always #5 clk = ~clk;

    eep_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_en_single_cycle", 32'(prev_wr_en), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                check("write_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
        prev_wr_en = wr_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered and left on a falling edge; a byte is offered only while in_ready is high.
    task automatic send_byte(input logic [7:0] b, input int idle);
        int t = 0;
        repeat (idle) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic send_all(input logic [7:0] bytes[$], input bit rnd);
        foreach (bytes[i]) send_byte(bytes[i], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs_async", {26'd0, in_ready, wr_en, cpu_run, load_err, 2'b00}, 32'd0);
        @(negedge clk);
        check("reset_addr_data", {wr_addr, wr_data}, 32'd0);
        check("reset_flags_held", {28'd0, in_ready, wr_en, cpu_run, load_err}, 32'd0);
        rst_n = 1'b1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    // Loads a word list that must succeed; expected writes are queued first.
    task automatic load_ok(input logic [15:0] words[$], input bit rnd, input string tag);
        logic [7:0]  b[$];
        logic [15:0] n;
`ifdef EEP_LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        n = 16'(words.size());
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        foreach (words[i]) begin
            exp_q.push_back({16'(i), words[i]});
            b.push_back(words[i][7:0]);
            b.push_back(words[i][15:8]);
`ifdef EEP_LOADER_CHECKSUM_EN
            cs = cs ^ words[i][7:0] ^ words[i][15:8];
`endif
        end
`ifdef EEP_LOADER_CHECKSUM_EN
        b.push_back(cs);
`endif
        for (int i = 0; i < b.size() - 1; i++) begin
            send_byte(b[i], rnd ? int'($urandom_range(0, 3)) : 0);
        end
        check({tag, "_cpu_run_before_last"}, 32'(cpu_run), 32'd0);
        send_byte(b[b.size()-1], rnd ? int'($urandom_range(0, 3)) : 0);
        check({tag, "_cpu_run_after_last"}, 32'(cpu_run), 32'd1);
        check({tag, "_ready_err_after_last"}, {30'd0, in_ready, load_err}, 32'd0);
        @(negedge clk);
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_cpu_run_held"}, 32'(cpu_run), 32'd1);
    endtask

    initial begin
        logic [15:0] w_basic[$];
        logic [15:0] w_none[$];
        logic [15:0] w_full[$];
        logic [7:0]  bytes[$];

        w_basic = '{16'h1234, 16'hABCD};
        for (int i = 0; i < DEPTH; i++) w_full.push_back(16'(i * 257) ^ 16'hA55A);

        @(negedge clk);
        do_reset();
        load_ok(w_basic, 1'b0, "basic");

        do_reset();
        load_ok(w_none, 1'b0, "zero_count");

        // Count 0x0101 exceeds DEPTH: straight to error, bytes afterwards are ignored.
        do_reset();
        bytes = '{8'h01, 8'h01};
        send_all(bytes, 1'b0);
        check("overflow_flags", {29'd0, load_err, cpu_run, in_ready}, 32'h4);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("overflow_sticky", {29'd0, load_err, cpu_run, in_ready}, 32'h4);

        // Reset after the third byte, then a complete reload from address 0.
        do_reset();
        bytes = '{8'h02, 8'h00, 8'h34};
        send_all(bytes, 1'b0);
        do_reset();
        load_ok(w_basic, 1'b0, "reload");

        do_reset();
        load_ok(w_basic, 1'b1, "gaps_a");
        do_reset();
        load_ok(w_basic, 1'b1, "gaps_b");

        do_reset();
        load_ok(w_full, 1'b1, "full_depth");

        do_reset();
`ifdef EEP_LOADER_CHECKSUM_EN
        bytes = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
        exp_q.push_back({16'h0000, 16'h00FF});
        send_all(bytes, 1'b0);
        check("bad_checksum_flags", {29'd0, load_err, cpu_run, in_ready}, 32'h4);
        @(negedge clk);
        check("bad_checksum_writes", 32'(exp_q.size()), 32'd0);
`else
        w_none = '{16'h00FF};
        load_ok(w_none, 1'b0, "single_word");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
